mux_unstriping: RTL
===================

# mux_unstriping

Receive-side counterpart of the two-lane byte-striping demux in the PCIe physical-layer datapath. It samples two 32-bit lanes on clk_2f in strict alternating order, lane 0 then lane 1, and rebuilds the original single word stream. The merged stream goes through a small FWFT buffer to a ready/valid consumer. Lane inputs cannot be back-pressured, so buffer overflow is detected, words are dropped, and a sticky flag is raised.

## Interface
- DATA_W, 32, lane and output word width
- FIFO_DEPTH, 4, output buffer depth in words; power of two, at least 2
- CNT_W, 16, width of word_count
- clk_2f  in  1  double-rate clock; all state changes on its rising edge
- reset  in  1  synchronous, active-low
- lane_0  in  DATA_W  lane 0 word
- valid_in0  in  1  lane 0 word valid
- lane_1  in  DATA_W  lane 1 word
- valid_in1  in  1  lane 1 word valid
- ready_out  in  1  downstream can accept a word this cycle
- data_out  out  DATA_W  head-of-buffer word; 0 when buffer empty
- valid_out  out  1  buffer non-empty
- fifo_full  out  1  buffer holds FIFO_DEPTH words
- overflow  out  1  sticky: a word was dropped because the buffer was full
- word_count  out  CNT_W  number of words accepted into the buffer; wraps modulo 2^CNT_W

## Operation
- **Lane-select FSM**, states LANE0 and LANE1; reset state LANE0.
  - LANE0 with valid_in0=1: capture lane_0, go to LANE1.
  - LANE1 with valid_in1=1: capture lane_1, go to LANE0.
  - Expected lane's valid=0: no capture, state holds.
  - The valid of the non-expected lane is ignored. It may be stale-high from the transmitter, and that is legal.
- **Capture** means one push into the buffer. Captured words are never reordered.
- **Push rules:**
  - Push when not full: write the word, increment word_count.
  - Push when full and pop in the same cycle: accepted, occupancy unchanged, word_count increments.
  - Push when full with no pop: word dropped, overflow set to 1, word_count unchanged.
  - The FSM still toggles after a dropped word, so lane alignment is preserved.
- **Pop:** occurs when valid_out=1 and ready_out=1. ready_out while empty is ignored.
- **Output:** data_out/valid_out/fifo_full are derived combinationally from buffer state (first-word-fall-through). data_out is forced to 0 when empty.
- **Reset values** (reset=0 at an edge): FSM=LANE0, pointers and occupancy 0, data_out=0, valid_out=0, fifo_full=0, overflow=0, word_count=0. Buffer contents are discarded.
- **Reset mid-stream:** any captured but unread words are lost. The first word after reset release is taken from lane 0.
- **Arithmetic:**
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Occupancy is log2(FIFO_DEPTH)+1 bits.
  - word_count wraps from 2^CNT_W-1 to 0 with no flag.

## Timing
- Lane sampled at edge N → word in buffer after edge N → valid_out=1 in cycle N+1 if the buffer was empty. Latency is 1 clk_2f.
- Pop at edge N → next word (or empty) visible in cycle N+1.
- Continuous striped input produces one capture per clk_2f, alternating lanes. Sustaining this requires ready_out=1 every cycle.
- Occupancy changes by at most ±1 per edge. Simultaneous push and pop leaves occupancy unchanged.
- overflow goes high in the cycle after the dropping edge and stays high until reset.

## Structure
- Package unstriping_pkg holds:
  - DATA_W, FIFO_DEPTH and CNT_W defaults.
  - The FSM state typedef with encoding LANE0=1'b0, LANE1=1'b1.
- Sub-module sync_fifo, parameterised by width and depth:
  - Inputs: push, pop, din.
  - Outputs: dout, empty, full, drop.
  - Pointers and occupancy live here.
- The top level holds the FSM, word_count, the overflow latch and the data_out zero-forcing.

## Test plan
- Reset check: hold reset=0 for 2 edges while lanes toggle → all outputs 0 and FSM in LANE0. Release reset, drive lane_0=0xA, valid_in0=1 → next cycle data_out=0xA, valid_out=1, word_count=1.
- In-order merge: words 0x1,0x2,0x3,0x4 alternately on lane 0/1, one per edge, with ready_out=1 → data_out sequence 0x1,0x2,0x3,0x4 on consecutive cycles, word_count=4, overflow=0.
- Stall and stale valid: after lane 0 word 0x10 is captured, hold valid_in1=0 for 3 edges with valid_in0 stale-high (lane_0=0x10) → no capture. Then lane_1=0x11, valid_in1=1 → output 0x10,0x11 only, never a duplicate 0x10.
- Overflow: ready_out=0 and 5 alternating words 0x20..0x24 → fifo_full=1 after the 4th word, 0x24 dropped, overflow=1, word_count=4. Then ready_out=1 → output 0x20..0x23 and valid_out=0 afterwards.
- Full with simultaneous pop: buffer full, ready_out=1, push 0x30 → accepted, fifo_full stays 1, overflow=0, 0x30 emitted after the 4 older words.
- Mid-stream reset: 3 words buffered, FSM in LANE1, then reset=0 for 1 edge → valid_out=0, word_count=0. Next valid_in1=1 alone is ignored; the next valid_in0=1 word is captured first.

Source files
------------

// File: rtl/unstriping_pkg.sv
// Shared defaults and lane-select state type for the two-lane unstriping datapath.
package unstriping_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned CNT_W_DEF      = 16;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through buffer; a push while full is accepted only if a pop frees a slot.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == (AW+1)'(DEPTH));
        do_pop  = pop & ~empty;
        // When full, wr_ptr == rd_ptr: the slot being popped is the one rewritten.
        do_push = push & (~full | do_pop);
        drop    = push & full & ~do_pop;
        dout    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mux_unstriping.sv
// Merges two strictly alternating 32-bit lanes back into one word stream feeding a ready/valid consumer.
module mux_unstriping
    import unstriping_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] lane_0,
    input  logic              valid_in0,
    input  logic [DATA_W-1:0] lane_1,
    input  logic              valid_in1,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              fifo_full,
    output logic              overflow,
    output logic [CNT_W-1:0]  word_count
);

    lane_state_t       state;
    logic              capture;
    logic [DATA_W-1:0] word;
    logic              pop;
    logic              drop;
    logic              empty;
    logic [DATA_W-1:0] head;

    // Only the expected lane's valid matters; the other may be stale-high.
    always_comb begin
        capture   = (state == LANE0) ? valid_in0 : valid_in1;
        word      = (state == LANE0) ? lane_0 : lane_1;
        valid_out = ~empty;
        pop       = valid_out & ready_out;
        data_out  = empty ? '0 : head;
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_2f),
        .reset (reset),
        .push  (capture),
        .pop   (pop),
        .din   (word),
        .dout  (head),
        .empty (empty),
        .full  (fifo_full),
        .drop  (drop)
    );

    // The FSM toggles on every capture, dropped or not, to keep lane alignment.
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            state      <= LANE0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (capture) begin
                state <= (state == LANE0) ? LANE1 : LANE0;
            end
            if (capture && !drop) begin
                word_count <= word_count + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
